booth_controller: RTL
=====================

BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 The module SHALL have this port: clk  input  1  rising-edge clock for all state.
REQ-002 The module SHALL have this port: rst_n  input  1  asynchronous active-low reset.
REQ-003 The module SHALL have this port: start  input  1  request a new 16-bit multiply; sampled in IDLE only.
REQ-004 The module SHALL have these ports: q0 and qm1  input  1 each  multiplier LSB and the Booth extra bit from the datapath.
REQ-005 The module SHALL have this port: cnt  input  5  iteration count from the downstream counter, which loads 5'b10000 on ld_cnt and decrements on dec_cnt.
REQ-006 The module SHALL have these load/clear ports: ld_m, ld_q, clr_a, clr_qm1, ld_a  output  1 each.
REQ-007 The module SHALL have these datapath-control ports: addsub (1=add, 0=subtract), sft  output  1 each; sft is the arithmetic right shift of A:Q:qm1.
REQ-008 The module SHALL have these counter-control ports: ld_cnt, dec_cnt  output  1 each.
REQ-009 The module SHALL have these status ports: busy, done  output  1 each.

Function
REQ-010 The module SHALL use these states: IDLE, LOAD_M, LOAD_Q, EVAL, ARITH, SHIFT, DONE, held in one state register.
REQ-011 All outputs SHALL be a Moore decode of the state register only; no output SHALL depend combinationally on any input.
REQ-012 In IDLE, all outputs SHALL be 0; start=1 SHALL move the FSM to LOAD_M, and start=0 SHALL keep it in IDLE.
REQ-013 LOAD_M SHALL assert ld_m for exactly one cycle, then go to LOAD_Q.
REQ-014 LOAD_Q SHALL assert ld_q, clr_a, clr_qm1 and ld_cnt together for one cycle, then go to EVAL.
REQ-015 EVAL SHALL assert no datapath strobes and SHALL decide the next state in this priority:
 - cnt==0: go to DONE.
 - {q0,qm1}==2'b10: go to ARITH with addsub=0 (subtract).
 - {q0,qm1}==2'b01: go to ARITH with addsub=1 (add).
 - {q0,qm1} of 00 or 11: go to SHIFT.
REQ-016 The FSM SHALL register the add/subtract choice on EVAL exit, so addsub stays stable for the whole ARITH cycle.
REQ-017 ARITH SHALL assert ld_a for one cycle, then go to SHIFT.
REQ-018 SHIFT SHALL assert sft and dec_cnt together for one cycle, then go to EVAL.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A 16-bit multiply SHALL take exactly 16 SHIFT visits.
REQ-022 Total latency from the start-sampling edge to done SHALL be 3 + 16*2 + k + 1 cycles, where k is the number of ARITH visits (0..16).
REQ-023 A start that arrives while not in IDLE SHALL be ignored and SHALL NOT be queued; start held high through DONE SHALL launch a new multiply on the first IDLE cycle.
REQ-024 An unencoded state value SHALL recover to IDLE on the next clock.
REQ-025 The block SHALL NOT assert ld_cnt and dec_cnt in the same cycle.

Reset
REQ-026 rst_n=0 SHALL force the state to IDLE and the registered addsub to 1 immediately, without waiting for a clock edge.
REQ-027 Reset SHALL drive every output to 0, including in the middle of a multiply.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL sample start normally.
REQ-029 The counter holds no reset; the controller SHALL reinitialise it through ld_cnt in LOAD_Q before reading cnt in any EVAL.

Configuration
REQ-030 With macro BOOTH_ABORT_EN defined, the module SHALL add input abort (1 bit).
REQ-031 With BOOTH_ABORT_EN defined, abort=1 in any state other than IDLE or DONE SHALL move the FSM to IDLE on the next edge with done=0, and abort SHALL take priority over every other transition.
REQ-032 Without BOOTH_ABORT_EN, the abort port and its logic SHALL be absent, and a multiply SHALL always run to DONE.

Verification
REQ-033 Reset test: rst_n=0 mid-SHIFT with no clock edge -> all outputs 0 and state IDLE; after release with start=0 for 5 cycles, busy stays 0.
REQ-034 No-op pattern test: start=1 with q0,qm1 held at 00 and cnt modelled 16 down to 0 -> 16 SHIFT pulses, 0 ld_a pulses, done exactly 36 cycles after start is sampled.
REQ-035 Alternating pattern test: q0,qm1 alternating 10/01 on every EVAL -> 16 ld_a pulses with addsub alternating 0,1,..., done 52 cycles after start.
REQ-036 Full-product test: the bench pairs the controller with the counter and a 16-bit datapath model; M=16'h0007, Q=16'hFFFD -> product 32'hFFFFFFEB; M=16'h8000, Q=16'h8000 -> product 32'h40000000.
REQ-037 Busy-start test: start pulsed during ARITH -> ignored, no second LOAD_M; start held through DONE -> LOAD_M on the cycle after IDLE.
REQ-038 Abort test (BOOTH_ABORT_EN defined): abort=1 in the 5th EVAL -> IDLE next cycle, done never asserted, and the next start runs a full multiply correctly.

Source files
------------

// File: rtl/booth_controller.sv
// Moore FSM that sequences a radix-2 Booth 16x16 signed multiply over an external A:Q:qm1 datapath.
// Define BOOTH_ABORT_EN to add the abort input, which cancels a multiply in progress.
module booth_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q0,
  input  logic       qm1,
  input  logic [4:0] cnt,
`ifdef BOOTH_ABORT_EN
  input  logic       abort,
`endif
  output logic       ld_m,
  output logic       ld_q,
  output logic       clr_a,
  output logic       clr_qm1,
  output logic       ld_a,
  output logic       addsub,
  output logic       sft,
  output logic       ld_cnt,
  output logic       dec_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    EVAL   = 3'd3,
    ARITH  = 3'd4,
    SHIFT  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t state, state_nxt;
  logic   addsub_r, addsub_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addsub_r <= 1'b1;
    end else begin
      state    <= state_nxt;
      addsub_r <= addsub_nxt;
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    addsub_nxt = addsub_r;
    ld_m       = 1'b0;
    ld_q       = 1'b0;
    clr_a      = 1'b0;
    clr_qm1    = 1'b0;
    ld_a       = 1'b0;
    addsub     = 1'b0;
    sft        = 1'b0;
    ld_cnt     = 1'b0;
    dec_cnt    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: state_nxt = start ? LOAD_M : IDLE;
      LOAD_M: begin
        ld_m      = 1'b1;
        busy      = 1'b1;
        state_nxt = LOAD_Q;
      end
      LOAD_Q: begin
        ld_q      = 1'b1;
        clr_a     = 1'b1;
        clr_qm1   = 1'b1;
        ld_cnt    = 1'b1;
        busy      = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end else if ({q0, qm1} == 2'b10) begin
          state_nxt  = ARITH;
          addsub_nxt = 1'b0;
        end else if ({q0, qm1} == 2'b01) begin
          state_nxt  = ARITH;
          addsub_nxt = 1'b1;
        end else begin
          state_nxt = SHIFT;
        end
      end
      ARITH: begin
        // addsub is gated to ARITH so every other state presents all-zero strobes
        ld_a      = 1'b1;
        addsub    = addsub_r;
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sft       = 1'b1;
        dec_cnt   = 1'b1;
        busy      = 1'b1;
        state_nxt = EVAL;
      end
      DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef BOOTH_ABORT_EN
    if (abort && (state != IDLE) && (state != DONE)) begin
      state_nxt  = IDLE;
      addsub_nxt = addsub_r;
    end
`endif
  end

endmodule
